header_receiver: RTL and testbench

Assembles the fixed-length block header sent by the host over the serial link into one wide register for the hashing core. It is the receiving end of the host-to-FPGA direction of the miner's serial protocol; the nonce result travels back over the transmit path. It sits between the UART receiver and the hash pipeline. It consumes one strobed byte at a time and adds byte counting, frame abort on line error or inter-byte timeout, and a valid/ack handoff so a header is never overwritten before the core takes it.

---
 rtl/header_receiver.sv | 106 ++++++++++
 tb/tb_header_receiver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/header_receiver.sv
`default_nettype none
// ============================================================================
// Module  : header_receiver
// Brief   : Assembles a fixed-length block header from strobed UART bytes,
//           with frame abort, inter-byte timeout and valid/ack handoff.
// Revision: 1.0
// ============================================================================
module header_receiver #(
    parameter int HEADER_BYTES   = 80,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_valid,
    input  logic                                frame_error,
    input  logic                                header_ack,
    output logic [8*HEADER_BYTES-1:0]           header,
    output logic                                header_valid,
    output logic [$clog2(HEADER_BYTES+1)-1:0]   byte_count,
    output logic [15:0]                         drop_count,
    output logic [15:0]                         abort_count
);

    localparam int CW = $clog2(HEADER_BYTES+1);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BYTE  = CW'(HEADER_BYTES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   idle_timer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            idle_timer   <= '0;
            header       <= '0;
            header_valid <= 1'b0;
            byte_count   <= '0;
            drop_count   <= '0;
            abort_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idle_timer <= '0;
                    if (frame_error) begin
                        if (abort_count != 16'hFFFF) abort_count <= abort_count + 16'd1;
                    end else if (rx_valid) begin
                        header     <= {header[8*HEADER_BYTES-9:0], rx_data};
                        byte_count <= CW'(1);
                        state      <= S_RECV;
                    end
                end
                S_RECV: begin
                    // A byte landing on the expiry cycle wins over the timeout.
                    if (frame_error || (!rx_valid && idle_timer == TIMER_LAST)) begin
                        byte_count <= '0;
                        idle_timer <= '0;
                        state      <= S_IDLE;
                        if (abort_count != 16'hFFFF) abort_count <= abort_count + 16'd1;
                    end else if (rx_valid) begin
                        header     <= {header[8*HEADER_BYTES-9:0], rx_data};
                        byte_count <= byte_count + CW'(1);
                        idle_timer <= '0;
                        if (byte_count == LAST_BYTE) begin
                            state        <= S_FULL;
                            header_valid <= 1'b1;
                        end
                    end else begin
                        idle_timer <= idle_timer + TW'(1);
                    end
                end
                S_FULL: begin
                    idle_timer <= '0;
                    if (header_ack) begin
                        header_valid <= 1'b0;
                        if (rx_valid) begin
                            header     <= {header[8*HEADER_BYTES-9:0], rx_data};
                            byte_count <= CW'(1);
                            state      <= S_RECV;
                        end else begin
                            byte_count <= '0;
                            state      <= S_IDLE;
                        end
                    end else if (rx_valid && drop_count != 16'hFFFF) begin
                        drop_count <= drop_count + 16'd1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    idle_timer   <= '0;
                    byte_count   <= '0;
                    header_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_header_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_header_receiver
// Brief   : Directed plus randomized bench for header_receiver (small and
//           default-size instances) against a frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_header_receiver;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic [7:0]  s_data;
    logic        s_valid, s_fe, s_ack;
    logic [31:0] s_header;
    logic        s_hv;
    logic [2:0]  s_bc;
    logic [15:0] s_drop, s_abort;

    logic [7:0]   b_data;
    logic         b_valid, b_fe, b_ack;
    logic [639:0] b_header;
    logic         b_hv;
    logic [6:0]   b_bc;
    logic [15:0]  b_drop, b_abort;

    header_receiver #(.HEADER_BYTES(4), .TIMEOUT_CYCLES(16)) dut_s (
        .clock(clock), .reset(reset), .rx_data(s_data), .rx_valid(s_valid),
        .frame_error(s_fe), .header_ack(s_ack), .header(s_header),
        .header_valid(s_hv), .byte_count(s_bc), .drop_count(s_drop),
        .abort_count(s_abort)
    );

    header_receiver dut_b (
        .clock(clock), .reset(reset), .rx_data(b_data), .rx_valid(b_valid),
        .frame_error(b_fe), .header_ack(b_ack), .header(b_header),
        .header_valid(b_hv), .byte_count(b_bc), .drop_count(b_drop),
        .abort_count(b_abort)
    );

    int checks = 0;
    int passed = 0;

    // Reference model of the small instance: frame fill level, idle run length.
    int          m_cnt, m_idle, m_drop, m_abort;
    bit          m_full;
    logic [31:0] m_hdr;

    task automatic check(string tag, logic [639:0] obs, logic [639:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idle = 0; m_drop = 0; m_abort = 0; m_full = 0; m_hdr = '0;
    endtask

    task automatic model_abort();
        m_cnt = 0;
        m_idle = 0;
        if (m_abort < 65535) m_abort++;
    endtask

    task automatic model_accept(logic [7:0] d);
        m_hdr = {m_hdr[23:0], d};
        m_cnt++;
        m_idle = 0;
        if (m_cnt == 4) m_full = 1;
    endtask

    task automatic model_step(bit v, logic [7:0] d, bit fe, bit ack);
        if (m_full) begin
            if (ack) begin
                m_full = 0;
                m_cnt  = 0;
                if (v) model_accept(d);
            end else if (v && m_drop < 65535) begin
                m_drop++;
            end
        end else if (fe) begin
            model_abort();
        end else if (v) begin
            model_accept(d);
        end else if (m_cnt != 0) begin
            m_idle++;
            if (m_idle == 16) model_abort();
        end
    endtask

    task automatic s_step(bit v, logic [7:0] d, bit fe, bit ack);
        s_valid = v; s_data = d; s_fe = fe; s_ack = ack;
        @(posedge clock);
        #1;
        model_step(v, d, fe, ack);
        s_valid = 1'b0; s_fe = 1'b0; s_ack = 1'b0;
        check("s_header", s_header, m_hdr);
        check("s_valid",  s_hv, m_full);
        check("s_count",  s_bc, m_cnt);
        check("s_drop",   s_drop, m_drop);
        check("s_abort",  s_abort, m_abort);
    endtask

    initial begin
        logic [639:0] big_exp;
        int density;
        reset = 1'b0;
        s_data = '0; s_valid = 0; s_fe = 0; s_ack = 0;
        b_data = '0; b_valid = 0; b_fe = 0; b_ack = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_s_header", s_header, 0);
        check("rst_s_valid",  s_hv, 0);
        check("rst_s_count",  s_bc, 0);
        check("rst_b_header", b_header, 0);
        check("rst_b_counts", {b_bc, b_drop, b_abort}, 0);
        reset = 1'b1;

        // Basic frame and ack.
        s_step(1, 8'h12, 0, 0);
        s_step(1, 8'h34, 0, 0);
        s_step(1, 8'h56, 0, 0);
        check("pre_last_valid", s_hv, 0);
        s_step(1, 8'h78, 0, 0);
        check("frame_header", s_header, 32'h12345678);
        check("frame_valid", s_hv, 1);
        check("frame_count", s_bc, 4);
        s_step(0, 8'h00, 0, 1);
        check("ack_valid", s_hv, 0);
        check("ack_count", s_bc, 0);

        // Timeout abort, then byte arriving on the expiry cycle.
        s_step(1, 8'hA1, 0, 0);
        s_step(1, 8'hA2, 0, 0);
        repeat (16) s_step(0, 8'h00, 0, 0);
        check("timeout_count", s_bc, 0);
        check("timeout_abort", s_abort, 1);
        s_step(1, 8'hB1, 0, 0);
        s_step(1, 8'hB2, 0, 0);
        repeat (15) s_step(0, 8'h00, 0, 0);
        s_step(1, 8'hB3, 0, 0);
        check("late_byte_count", s_bc, 3);
        check("late_byte_abort", s_abort, 1);
        s_step(0, 8'h00, 1, 0);
        check("fe_only_abort", s_abort, 2);

        // Drops while full, frame_error ignored, ack coincident with a byte.
        s_step(1, 8'h01, 0, 0);
        s_step(1, 8'h02, 0, 0);
        s_step(1, 8'h03, 0, 0);
        s_step(1, 8'h04, 0, 0);
        s_step(1, 8'h11, 0, 0);
        s_step(1, 8'h22, 1, 0);
        s_step(1, 8'h33, 0, 0);
        check("full_hold_header", s_header, 32'h01020304);
        check("full_drop", s_drop, 3);
        check("full_fe_ignored", s_abort, 2);
        s_step(1, 8'hAA, 0, 1);
        check("ack_byte_count", s_bc, 1);
        check("ack_byte_low", s_header[7:0], 8'hAA);
        check("ack_byte_drop", s_drop, 3);
        s_step(0, 8'h00, 0, 1);
        check("ack_outside_full", s_bc, 1);
        s_step(0, 8'h00, 1, 0);

        // frame_error coincident with a byte, then a clean frame.
        s_step(1, 8'h55, 0, 0);
        s_step(1, 8'h66, 0, 0);
        s_step(1, 8'h77, 1, 0);
        check("fe_byte_count", s_bc, 0);
        check("fe_byte_abort", s_abort, 4);
        s_step(1, 8'hC0, 0, 0);
        s_step(1, 8'hC1, 0, 0);
        s_step(1, 8'hC2, 0, 0);
        s_step(1, 8'hC3, 0, 0);
        check("after_fe_header", s_header, 32'hC0C1C2C3);
        check("after_fe_valid", s_hv, 1);
        s_step(0, 8'h00, 0, 1);

        // Mid-frame reset clears everything immediately.
        s_step(1, 8'h91, 0, 0);
        s_step(1, 8'h92, 0, 0);
        s_step(1, 8'h93, 0, 0);
        reset = 1'b0;
        #1;
        check("async_rst_header", s_header, 0);
        check("async_rst_count", s_bc, 0);
        check("async_rst_ctrs", {s_drop, s_abort}, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        s_step(1, 8'hDE, 0, 0);
        s_step(1, 8'hAD, 0, 0);
        s_step(1, 8'hBE, 0, 0);
        s_step(1, 8'hEF, 0, 0);
        check("post_rst_header", s_header, 32'hDEADBEEF);
        s_step(0, 8'h00, 0, 1);

        // Randomized bursts of varying byte density.
        for (int burst = 0; burst < 40; burst++) begin
            density = int'($urandom_range(0, 4));
            for (int k = 0; k < 20; k++) begin
                s_step(($urandom_range(0, 3) < density),
                       8'($urandom),
                       ($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 4) == 0));
            end
        end

        // Default-size instance: full 80-byte frame.
        big_exp = '0;
        for (int i = 0; i < 80; i++) begin
            big_exp[8*(79-i) +: 8] = 8'(i);
            b_valid = 1'b1;
            b_data  = 8'(i);
            @(posedge clock);
            #1;
        end
        b_valid = 1'b0;
        check("big_top_byte", b_header[639:632], 8'h00);
        check("big_low_byte", b_header[7:0], 8'h4F);
        check("big_header", b_header, big_exp);
        check("big_valid", b_hv, 1);
        check("big_count", b_bc, 80);

        // Drop counter saturation while full.
        b_valid = 1'b1;
        b_data  = 8'h5A;
        repeat (65534) @(posedge clock);
        #1;
        check("drop_fffe", b_drop, 16'hFFFE);
        @(posedge clock);
        #1;
        check("drop_ffff", b_drop, 16'hFFFF);
        repeat (5) @(posedge clock);
        #1;
        b_valid = 1'b0;
        check("drop_saturated", b_drop, 16'hFFFF);
        check("big_header_frozen", b_header, big_exp);
        check("big_still_valid", b_hv, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
